// File: rtl/k_sort_pkg.sv
// Definitions shared by the top-K sorter and its result drain.
package k_sort_pkg;

    localparam int K_DEF_WIDTH = 32;
    localparam int K_DEF_K     = 20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_CLEAR
    } drain_state_t;

    // Width able to hold any count from 0 to k inclusive.
    function automatic int cw_of(input int k);
        return $clog2(k + 1);
    endfunction

endpackage

// File: rtl/k_drain.sv
// Snapshots the sorter's result arrays on start and streams them out in slot
// order with valid/ready, then pulses clear_req/done for one cycle.
module k_drain
    import k_sort_pkg::*;
#(
    parameter int   WIDTH = K_DEF_WIDTH,
    parameter int   K     = K_DEF_K,
    localparam int  CW    = cw_of(K)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_value [K],
    input  logic [WIDTH-1:0] in_index [K],
    input  logic [CW-1:0]    in_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_value,
    output logic [WIDTH-1:0] out_index,
    output logic [CW-1:0]    out_rank,
    output logic             out_last,
    output logic             busy,
    output logic             clear_req,
    output logic             done
);

    drain_state_t     state, state_nxt;
    logic [WIDTH-1:0] snap_value [K];
    logic [WIDTH-1:0] snap_index [K];
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    rank;
    logic [CW-1:0]    cnt_clamped;

    assign cnt_clamped = (in_count > CW'(K)) ? CW'(K) : in_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs are a pure function of the registered state, so an asserted
    // reset zeroes them without waiting for a clock edge.
    always_comb begin
        state_nxt = state;
        busy      = (state != ST_IDLE);
        clear_req = 1'b0;
        done      = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_value = '0;
        out_index = '0;
        out_rank  = '0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (cnt_clamped != '0) ? ST_STREAM : ST_CLEAR;
                end
            end
            ST_STREAM: begin
                out_valid = 1'b1;
                out_value = snap_value[rank];
                out_index = snap_index[rank];
                out_rank  = rank;
                out_last  = (rank == cnt - CW'(1));
                if (out_ready && out_last) begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                clear_req = 1'b1;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            rank <= '0;
            for (int unsigned i = 0; i < K; i++) begin
                snap_value[i] <= '0;
                snap_index[i] <= '0;
            end
        end else if (state == ST_IDLE && start) begin
            cnt  <= cnt_clamped;
            rank <= '0;
            for (int unsigned i = 0; i < K; i++) begin
                snap_value[i] <= in_value[i];
                snap_index[i] <= in_index[i];
            end
        end else if (state == ST_STREAM && out_ready && !out_last) begin
            rank <= rank + CW'(1);
        end
    end

endmodule

// File: tb/tb_k_drain.sv
// Scoreboard bench for k_drain: stimulus queues expected beats, a monitor
// pops and compares every accepted beat and checks stability under backpressure.
module tb_k_drain;

    localparam int WIDTH = 32;
    localparam int K     = 20;
    localparam int CW    = 5;

    typedef struct {
        logic [WIDTH-1:0] value;
        logic [WIDTH-1:0] index;
        logic [CW-1:0]    rank;
        logic             last;
    } beat_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] in_value [K];
    logic [WIDTH-1:0] in_index [K];
    logic [CW-1:0]    in_count;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_value;
    logic [WIDTH-1:0] out_index;
    logic [CW-1:0]    out_rank;
    logic             out_last;
    logic             busy;
    logic             clear_req;
    logic             done;

    beat_t exp_q[$];
    int    n_cmp;
    int    n_bad;

    k_drain #(.WIDTH(WIDTH), .K(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_value  (in_value),
        .in_index  (in_index),
        .in_count  (in_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_index (out_index),
        .out_rank  (out_rank),
        .out_last  (out_last),
        .busy      (busy),
        .clear_req (clear_req),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares accepted beats against the queue and requires a
    // stalled beat to be repeated unchanged on the following cycle.
    initial begin
        beat_t held;
        beat_t e;
        bit    hold_pending;
        hold_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (hold_pending) begin
                    chk("hold_value", out_value, held.value);
                    chk("hold_index", out_index, held.index);
                    chk("hold_rank",  out_rank,  held.rank);
                    chk("hold_last",  out_last,  held.last);
                end
                if (out_ready) begin
                    chk("beat_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("beat_value", out_value, e.value);
                        chk("beat_index", out_index, e.index);
                        chk("beat_rank",  out_rank,  e.rank);
                        chk("beat_last",  out_last,  e.last);
                    end
                end
            end
            hold_pending = out_valid && !out_ready;
            held.value   = out_value;
            held.index   = out_index;
            held.rank    = out_rank;
            held.last    = out_last;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns one ns after the edge that samples start, i.e. in cycle 1.
    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic push_beats(input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.value = in_value[i];
            b.index = in_index[i];
            b.rank  = CW'(i);
            b.last  = (i == n - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic load_basic();
        for (int i = 0; i < K; i++) begin
            in_value[i] = 32'hdead_0000 + i;
            in_index[i] = 32'hbeef_0000 + i;
        end
        in_value[0] = 5;  in_index[0] = 7;
        in_value[1] = 9;  in_index[1] = 2;
        in_value[2] = 12; in_index[2] = 4;
        in_count = 3;
    endtask

    initial begin
        int done_cycle;
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        in_count  = '0;
        for (int i = 0; i < K; i++) begin
            in_value[i] = '0;
            in_index[i] = '0;
        end
        #1;
        chk("reset_valid", out_valid, 0);
        chk("reset_busy",  busy, 0);
        chk("reset_done",  done, 0);
        chk("reset_clear", clear_req, 0);
        wait_cycles(2);
        rst = 1'b1;
        wait_cycles(1);

        // Basic drain
        load_basic();
        push_beats(3);
        pulse_start();
        chk("basic_c1_valid", out_valid, 1);
        chk("basic_c1_busy",  busy, 1);
        chk("basic_c1_value", out_value, 5);
        wait_cycles(2);
        chk("basic_c3_last", out_last, 1);
        wait_cycles(1);
        chk("basic_c4_clear", clear_req, 1);
        chk("basic_c4_done",  done, 1);
        chk("basic_c4_valid", out_valid, 0);
        wait_cycles(1);
        chk("basic_idle_busy", busy, 0);
        chk("basic_idle_done", done, 0);
        chk("basic_q_empty", exp_q.size(), 0);

        // Backpressure at rank 1
        load_basic();
        push_beats(3);
        pulse_start();
        wait_cycles(1);
        out_ready = 1'b0;
        chk("bp_c2_value", out_value, 9);
        chk("bp_c2_index", out_index, 2);
        wait_cycles(3);
        chk("bp_c5_value", out_value, 9);
        chk("bp_c5_rank",  out_rank, 1);
        wait_cycles(1);
        out_ready = 1'b1;
        wait_cycles(2);
        chk("bp_c8_done", done, 1);
        chk("bp_q_empty", exp_q.size(), 0);
        wait_cycles(1);

        // Empty drain
        in_count = 0;
        pulse_start();
        chk("empty_c1_valid", out_valid, 0);
        chk("empty_c1_clear", clear_req, 1);
        chk("empty_c1_done",  done, 1);
        chk("empty_c1_busy",  busy, 1);
        wait_cycles(1);
        chk("empty_c2_busy", busy, 0);
        chk("empty_c2_done", done, 0);

        // Full drain with clamp
        for (int i = 0; i < K; i++) begin
            in_value[i] = 3 * i + 1;
            in_index[i] = 100 + i;
        end
        in_count = 31;
        push_beats(K);
        pulse_start();
        done_cycle = -1;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                done_cycle = c;
                break;
            end
            wait_cycles(1);
        end
        chk("full_done_cycle", done_cycle, 21);
        chk("full_q_empty", exp_q.size(), 0);
        wait_cycles(1);

        // Input isolation: live inputs and start change mid-drain
        for (int i = 0; i < K; i++) begin
            in_value[i] = 1000 + i;
            in_index[i] = 2000 + i;
        end
        in_count = 4;
        push_beats(4);
        pulse_start();
        wait_cycles(1);
        for (int i = 0; i < K; i++) in_value[i] = 999;
        in_count = 2;
        start    = 1'b1;
        wait_cycles(1);
        start = 1'b0;
        wait_cycles(2);
        chk("iso_c5_done", done, 1);
        wait_cycles(1);
        chk("iso_c6_busy", busy, 0);
        wait_cycles(1);
        chk("iso_c7_busy", busy, 0);
        chk("iso_q_empty", exp_q.size(), 0);

        // Reset mid-stream at rank 2 of 5
        for (int i = 0; i < K; i++) begin
            in_value[i] = 10 + i;
            in_index[i] = 20 + i;
        end
        in_count = 5;
        push_beats(5);
        pulse_start();
        wait_cycles(2);
        chk("rst_pre_rank", out_rank, 2);
        rst = 1'b0;
        #1;
        exp_q.delete();
        chk("rst_valid", out_valid, 0);
        chk("rst_value", out_value, 0);
        chk("rst_index", out_index, 0);
        chk("rst_rank",  out_rank, 0);
        chk("rst_last",  out_last, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_clear", clear_req, 0);
        chk("rst_done",  done, 0);
        wait_cycles(1);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            wait_cycles(1);
            chk("rst_after_done",  done, 0);
            chk("rst_after_clear", clear_req, 0);
            chk("rst_after_busy",  busy, 0);
        end
        in_value[0] = 50; in_index[0] = 51;
        in_value[1] = 60; in_index[1] = 61;
        in_count = 2;
        push_beats(2);
        pulse_start();
        chk("rst_new_rank",  out_rank, 0);
        chk("rst_new_value", out_value, 50);
        wait_cycles(2);
        chk("rst_new_done", done, 1);
        wait_cycles(2);
        chk("final_q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/k_drain.md
K_DRAIN -- requirements
Module: k_drain

Interface
REQ-001 Parameter WIDTH, default 32: bit width of each value and index word.
REQ-002 Parameter K, default 20: number of sorted result slots supplied by the sorter.
REQ-003 Derived constant CW SHALL be $clog2(K+1): width of count and rank fields.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to snapshot the sorter's result arrays.
REQ-007 in_value  input  WIDTH x K (unpacked array)  sorted values, slot 0 = best.
REQ-008 in_index  input  WIDTH x K (unpacked array)  index paired with each slot.
REQ-009 in_count  input  CW  number of filled slots, 0..K.
REQ-010 out_valid  output  1  out_value/out_index/out_rank/out_last hold a valid entry.
REQ-011 out_ready  input  1  downstream accepts the entry this cycle.
REQ-012 out_value, out_index  output  WIDTH each  current entry.
REQ-013 out_rank  output  CW  slot number of the current entry.
REQ-014 out_last  output  1  the current entry is the final entry.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 clear_req  output  1  one-cycle pulse telling the sorter to clear its registers.
REQ-017 done  output  1  one-cycle pulse marking the end of a drain.

Function
REQ-018 FSM states SHALL be IDLE, STREAM and CLEAR.
REQ-019 IDLE with start=1: snapshot in_value, in_index and cnt=min(in_count,K) into internal registers on that edge; set rank=0.
REQ-020 After the snapshot: go to STREAM if cnt>0, go to CLEAR if cnt==0.
REQ-021 Latency: start sampled at edge N SHALL give out_valid=1 after edge N (the first entry is visible in cycle N+1).
REQ-022 STREAM: out_valid=1; outputs are taken from snapshot slot rank; out_last=(rank==cnt-1).
REQ-023 A transfer SHALL occur only on a cycle with out_valid && out_ready.
REQ-024 While out_valid=1 and out_ready=0, all outputs SHALL hold stable.
REQ-025 On a transfer with out_last=0: rank increments by 1.
REQ-026 On a transfer with out_last=1: go to CLEAR and drop out_valid on the next cycle.
REQ-027 CLEAR lasts exactly one cycle, with clear_req=1 and done=1; then return to IDLE.
REQ-028 start SHALL be ignored outside IDLE; live input changes after the snapshot SHALL NOT affect the drain in progress.
REQ-029 in_count>K SHALL be clamped to K.
REQ-030 Entries SHALL be emitted in slot order 0..cnt-1, each exactly once, with no gaps or repeats.
REQ-031 When not in STREAM: out_valid=0, out_last=0, out_value/out_index/out_rank=0.

Reset
REQ-032 rst low SHALL immediately force state=IDLE, rank=0, cnt=0, snapshot registers=0.
REQ-033 rst low SHALL immediately force all outputs to 0 (out_valid, out_last, busy, clear_req, done, data fields).
REQ-034 Reset during STREAM SHALL abandon the drain with no clear_req or done pulse; the next start begins a fresh drain.

Structure
REQ-035 A shared package k_sort_pkg SHALL hold the state enum, the CW width function and default WIDTH/K constants, for use by the sorter and this block.
REQ-036 The block SHALL be a single module with no sub-modules; the snapshot registers, rank counter and FSM live in k_drain.

Verification
REQ-037 Basic drain: K=20, in_count=3, values {5,9,12}, indices {7,2,4}, start, out_ready=1 -> three beats in cycles 1-3 with rank 0,1,2; out_last on the third beat; clear_req=done=1 in cycle 4.
REQ-038 Backpressure: as REQ-037 with out_ready=0 for 4 cycles at rank 1 -> value 9 / index 2 held stable for 4 cycles; no beat lost or repeated.
REQ-039 Empty drain: in_count=0, start -> no out_valid; clear_req and done in cycle 1; busy high for one cycle only.
REQ-040 Full drain and clamp: in_count=31, K=20 -> exactly 20 beats, out_last at rank 19.
REQ-041 Input isolation: change in_value and pulse start during STREAM -> emitted data unchanged; no second drain starts.
REQ-042 Reset mid-stream: drop rst at rank 2 of 5 -> all outputs 0 immediately; no clear_req or done; a later start drains the new snapshot from rank 0.
